// File: rtl/hex_message_scroller_if.sv
// Nibble write port of the hex message scroller: valid/ready handshake.
// The master drives valid and data; the scroller answers with ready.
interface hex_message_scroller_if;
   logic       wr_valid;
   logic [3:0] wr_data;
   logic       wr_ready;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/hex_message_scroller.sv
// Message buffer of hex nibbles shown as a scrolling NUM_HEX-digit window.
// The window advances on a prescaled tick or on a step pulse, with GAP blanks between repeats.
module hex_message_scroller #(
   parameter int NUM_HEX  = 6,
   parameter int MAX_LEN  = 16,
   parameter int TICK_DIV = 50000000,
   parameter int GAP      = 2
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic                   i_clear,
   hex_message_scroller_if.slave  wr,
   input  logic                   i_enable,
   input  logic                   i_step,
   output logic [3:0]             o_hex [NUM_HEX],
   output logic [NUM_HEX-1:0]     o_blank,
   output logic                   o_wrap
);

   localparam int POS_W  = $clog2(MAX_LEN + GAP + 1);
   localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CNT_W  = $clog2(TICK_DIV);

   logic [3:0]         buf_q [MAX_LEN];
   logic [POS_W-1:0]   len_q, len_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wrap_evt_q, wrap_evt_d;
   logic               wrap_q, wrap_d;
   logic [3:0]         hex_q [NUM_HEX];
   logic [3:0]         hex_d [NUM_HEX];
   logic [NUM_HEX-1:0] blank_q, blank_d;

   logic [POS_W-1:0]   virt_len;
   logic [POS_W-1:0]   virt_idx [NUM_HEX];
   logic               wr_fire;
   logic               running;
   logic               tick;
   logic               advance;

   assign wr.wr_ready = (len_q < POS_W'(MAX_LEN)) && !i_clear;
   assign wr_fire     = wr.wr_valid && wr.wr_ready;
   assign virt_len    = len_q + POS_W'(GAP);
   assign running     = i_enable && (len_q != '0);
   assign tick        = running && (cnt_q == CNT_W'(TICK_DIV - 1));
   assign advance     = (tick || i_step) && (len_q != '0);

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      len_d      = len_q;
      pos_d      = pos_q;
      cnt_d      = cnt_q;
      wrap_evt_d = 1'b0;
      if (i_clear) begin
         len_d = '0;
         pos_d = '0;
         cnt_d = '0;
      end else begin
         if (running) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
         end
         if (wr_fire) begin
            len_d = len_q + POS_W'(1);
         end
         if (advance) begin
            if (pos_q == virt_len - POS_W'(1)) begin
               pos_d      = '0;
               wrap_evt_d = 1'b1;
            end else begin
               pos_d = pos_q + POS_W'(1);
            end
         end
      end
   end

   // Walk left to right with a wrapping increment; exact even when the window is wider than L.
   always_comb begin
      virt_idx[NUM_HEX-1] = pos_q;
      for (int k = NUM_HEX - 2; k >= 0; k--) begin
         virt_idx[k] = (virt_idx[k+1] == virt_len - POS_W'(1)) ? '0 : virt_idx[k+1] + POS_W'(1);
      end
      for (int k = 0; k < NUM_HEX; k++) begin
         hex_d[k]   = 4'h0;
         blank_d[k] = 1'b1;
         if (virt_idx[k] < len_q) begin
            hex_d[k]   = buf_q[virt_idx[k][BUF_AW-1:0]];
            blank_d[k] = 1'b0;
         end
      end
   end

   // The wrap pulse lines up with the first display cycle that shows pos 0.
   assign wrap_d = wrap_evt_q;

   // NOTE: sequential state is assigned with non-blocking <= only, so every flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         len_q      <= '0;
         pos_q      <= '0;
         cnt_q      <= '0;
         wrap_evt_q <= 1'b0;
         wrap_q     <= 1'b0;
         blank_q    <= '1;
         for (int k = 0; k < NUM_HEX; k++) begin
            hex_q[k] <= 4'h0;
         end
      end else begin
         len_q      <= len_d;
         pos_q      <= pos_d;
         cnt_q      <= cnt_d;
         wrap_evt_q <= wrap_evt_d;
         wrap_q     <= wrap_d;
         blank_q    <= blank_d;
         hex_q      <= hex_d;
      end
   end

   // NOTE: the message buffer has no reset; entries at or above len are never displayed.
   always_ff @(posedge i_clock) begin
      if (wr_fire) begin
         buf_q[len_q[BUF_AW-1:0]] <= wr.wr_data;
      end
   end

   assign o_hex   = hex_q;
   assign o_blank = blank_q;
   assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_hex_message_scroller.sv
// Directed bench for hex_message_scroller with a short tick period (TICK_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hex_message_scroller;

   localparam int NUM_HEX  = 6;
   localparam int MAX_LEN  = 16;
   localparam int TICK_DIV = 4;
   localparam int GAP      = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               clear;
   logic               enable;
   logic               step;
   logic [3:0]         hex [NUM_HEX];
   logic [NUM_HEX-1:0] blank;
   logic               wrap;

   int checks = 0;
   int errors = 0;

   hex_message_scroller_if wr_if ();

   hex_message_scroller #(
      .NUM_HEX  (NUM_HEX),
      .MAX_LEN  (MAX_LEN),
      .TICK_DIV (TICK_DIV),
      .GAP      (GAP)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_clear   (clear),
      .wr        (wr_if),
      .i_enable  (enable),
      .i_step    (step),
      .o_hex     (hex),
      .o_blank   (blank),
      .o_wrap    (wrap)
   );

   always #5 clk = ~clk;

   // Leftmost digit ends up in the top nibble, so 24'h123001 reads "1 2 3 0 0 1".
   function automatic logic [23:0] packed_hex();
      logic [23:0] h;
      for (int i = 0; i < NUM_HEX; i++) begin
         h[4*i +: 4] = hex[i];
      end
      return h;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_win(input string tag, input logic [23:0] exp_hex, input logic [5:0] exp_blank);
      check({tag, ".hex"}, {8'h0, packed_hex()}, {8'h0, exp_hex});
      check({tag, ".blank"}, {26'h0, blank}, {26'h0, exp_blank});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr_nibble(input logic [3:0] d);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = d;
      cyc(1);
      wr_if.wr_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b1;
      clear          = 1'b0;
      enable         = 1'b0;
      step           = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 4'h0;

      // 1: reset state, empty buffer ignores steps
      #2 rst_n = 1'b0;
      #1;
      check_win("reset", 24'h000000, 6'b111111);
      check("reset.wrap", {31'h0, wrap}, 32'h0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      check("idle.ready", {31'h0, wr_if.wr_ready}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         step = (i % 2 == 0);
         cyc(1);
         check("idle.wrap", {31'h0, wrap}, 32'h0);
      end
      step = 1'b0;
      cyc(1);
      check_win("idle", 24'h000000, 6'b111111);

      // 2: three nibbles with GAP=2, then one manual step
      wr_nibble(4'h1);
      wr_nibble(4'h2);
      wr_nibble(4'h3);
      cyc(1);
      check_win("msg3.pos0", 24'h123001, 6'b000110);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check_win("step.latency", 24'h123001, 6'b000110);
      cyc(1);
      check_win("step.pos1", 24'h230012, 6'b001100);

      // 3: auto-scroll every 4 cycles, wrap pulse, step coincident with tick
      enable = 1'b1;
      cyc(4);
      check_win("tick.before", 24'h230012, 6'b001100);
      cyc(1);
      check_win("tick.pos2", 24'h300123, 6'b011000);
      cyc(11);
      check_win("tick.pos4", 24'h012300, 6'b100011);
      check("tick.nowrap", {31'h0, wrap}, 32'h0);
      cyc(1);
      check("wrap.high", {31'h0, wrap}, 32'h1);
      check_win("wrap.pos0", 24'h123001, 6'b000110);
      cyc(1);
      check("wrap.low", {31'h0, wrap}, 32'h0);
      cyc(1);
      step = 1'b1;
      cyc(1);
      step   = 1'b0;
      enable = 1'b0;
      cyc(1);
      check_win("tick_step.once", 24'h230012, 6'b001100);
      check("tick_step.wrap", {31'h0, wrap}, 32'h0);

      // Counter holds while disabled and resumes
      enable = 1'b1;
      cyc(2);
      enable = 1'b0;
      cyc(5);
      enable = 1'b1;
      cyc(2);
      enable = 1'b0;
      check_win("hold.before", 24'h230012, 6'b001100);
      cyc(1);
      check_win("hold.resume", 24'h300123, 6'b011000);

      // 5: clear wins over coincident write and step
      clear          = 1'b1;
      step           = 1'b1;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 4'hF;
      #1;
      check("clear.ready", {31'h0, wr_if.wr_ready}, 32'h0);
      cyc(1);
      clear          = 1'b0;
      step           = 1'b0;
      wr_if.wr_valid = 1'b0;
      check_win("clear.latency", 24'h300123, 6'b011000);
      cyc(1);
      check_win("clear.blank", 24'h000000, 6'b111111);
      check("clear.wrap", {31'h0, wrap}, 32'h0);
      cyc(3);
      check("clear.wrap2", {31'h0, wrap}, 32'h0);
      wr_nibble(4'h5);
      cyc(1);
      check_win("clear.refill", 24'h500500, 6'b011011);

      // 4: overfill with 17 back-to-back writes
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_data  = 4'(i + 1);
         cyc(1);
         if (i == 14) check("fill.ready15", {31'h0, wr_if.wr_ready}, 32'h1);
         if (i == 15) check("fill.ready16", {31'h0, wr_if.wr_ready}, 32'h0);
      end
      wr_if.wr_valid = 1'b0;
      cyc(1);
      check_win("full.pos0", 24'h123456, 6'b000000);
      step = 1'b1;
      cyc(12);
      step = 1'b0;
      cyc(1);
      check_win("full.pos12", 24'hDEF000, 6'b000011);
      clear = 1'b1;
      #1;
      check("full.clear_ready", {31'h0, wr_if.wr_ready}, 32'h0);
      cyc(1);
      clear = 1'b0;
      #1;
      check("full.ready_back", {31'h0, wr_if.wr_ready}, 32'h1);

      // 6: asynchronous reset mid-scroll
      cyc(1);
      wr_nibble(4'h7);
      wr_nibble(4'h8);
      wr_nibble(4'h9);
      enable = 1'b1;
      cyc(6);
      #2 rst_n = 1'b0;
      #1;
      check_win("areset", 24'h000000, 6'b111111);
      check("areset.wrap", {31'h0, wrap}, 32'h0);
      cyc(1);
      rst_n = 1'b1;
      step  = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(6);
      check_win("post_reset.idle", 24'h000000, 6'b111111);
      check("post_reset.ready", {31'h0, wr_if.wr_ready}, 32'h1);
      enable = 1'b0;
      wr_nibble(4'hA);
      cyc(1);
      check_win("post_reset.refill", 24'hA00A00, 6'b011011);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
